// File: rtl/return_stack_pkg.sv
// ---------------------------------------------------------------------------
// return_stack_pkg
// Shared definitions for the return-address stack:
//   - full-stack policy selectors used as the WRAP parameter value
//   - modulo pointer step helpers that work for any DEPTH >= 2
// ---------------------------------------------------------------------------
package return_stack_pkg;

  // Full-stack policy: reject the push, or overwrite the oldest entry.
  localparam int POLICY_REJECT    = 0;
  localparam int POLICY_OVERWRITE = 1;

  // Compare-and-wrap rather than bit truncation, so DEPTH need not be 2^n.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int unsigned ptr_dec(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr == 0) ? depth - 1 : ptr - 1;
  endfunction

endpackage

// File: rtl/return_stack_entry_bank.sv
// ---------------------------------------------------------------------------
// stack_entry_bank
// DEPTH x WIDTH register array holding the stack entries. Contents are not
// reset; validity is tracked by the owner through its entry count.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write address (0..DEPTH-1)
//   i_wdata  write data
//   i_raddr  read address (0..DEPTH-1)
//   o_rdata  asynchronous read data
// ---------------------------------------------------------------------------
module stack_entry_bank #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (i_we && (i_waddr == AW'(gi))) begin
          r_mem[gi] <= i_wdata;
        end
      end
    end
  endgenerate

  // The owner only ever presents in-range read addresses.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_stack.sv
// ---------------------------------------------------------------------------
// return_stack
// LIFO of return PCs for call/return. The top of stack is visible on q with
// no read latency; push/pop take effect on the sampling posedge.
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   push/pop   stack operations (both high on a non-empty stack = replace top)
//   d          value to push
//   q          top entry, 0 when empty
//   count      number of valid entries
//   empty/full status derived from count
//   overflow   sticky: push on full (rejected or overwriting oldest)
//   underflow  sticky: pop while empty
//   clr_err    clears both sticky flags (a new error in the same cycle wins)
// ---------------------------------------------------------------------------
module return_stack
  import return_stack_pkg::*;
#(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 8,
  parameter  int WRAP  = POLICY_REJECT,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int PTR_W = $clog2(DEPTH);

  // r_top is the next free slot. The oldest entry is implied by r_top and
  // r_count, so overwriting in ring mode needs no separate bottom register.
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_udf;

  logic [PTR_W-1:0] w_top_p1;
  logic [PTR_W-1:0] w_top_m1;
  logic [PTR_W-1:0] w_top_next;
  logic [PTR_W-1:0] w_waddr;
  logic [CNT_W-1:0] w_count_next;
  logic             w_we;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic             w_empty;
  logic             w_full;
  logic [WIDTH-1:0] w_rdata;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_top_p1 = PTR_W'(ptr_inc(32'(r_top), DEPTH));
  assign w_top_m1 = PTR_W'(ptr_dec(32'(r_top), DEPTH));

  always_comb begin
    w_top_next   = r_top;
    w_count_next = r_count;
    w_we         = 1'b0;
    w_waddr      = r_top;
    w_ovf_set    = 1'b0;
    w_udf_set    = 1'b0;
    if (push && pop && !w_empty) begin
      // Return-then-call: overwrite the top entry in place.
      w_we    = 1'b1;
      w_waddr = w_top_m1;
    end else if (push) begin
      // A pop alongside a push on an empty stack is ignored, no underflow.
      if (!w_full) begin
        w_we         = 1'b1;
        w_top_next   = w_top_p1;
        w_count_next = r_count + CNT_W'(1);
      end else if (WRAP == POLICY_OVERWRITE) begin
        // Full ring: the new entry lands on the oldest slot.
        w_we       = 1'b1;
        w_top_next = w_top_p1;
        w_ovf_set  = 1'b1;
      end else begin
        w_ovf_set = 1'b1;
      end
    end else if (pop) begin
      if (!w_empty) begin
        w_top_next   = w_top_m1;
        w_count_next = r_count - CNT_W'(1);
      end else begin
        w_udf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_top   <= w_top_next;
      r_count <= w_count_next;
      r_ovf   <= w_ovf_set | (r_ovf & ~clr_err);
      r_udf   <= w_udf_set | (r_udf & ~clr_err);
    end
  end

  stack_entry_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_bank (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (d),
    .i_raddr (w_top_m1),
    .o_rdata (w_rdata)
  );

  assign q         = w_empty ? '0 : w_rdata;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

// File: tb/tb_return_stack.sv
// ---------------------------------------------------------------------------
// tb_return_stack
// Drives a reject-policy and an overwrite-policy stack with identical
// stimulus and compares both against queue-based reference stacks.
// ---------------------------------------------------------------------------
module tb_return_stack;

  localparam int WIDTH = 12;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] d = '0;

  logic [WIDTH-1:0] q0, q1;
  logic [CW-1:0]    count0, count1;
  logic             empty0, empty1, full0, full1;
  logic             ovf0, ovf1, udf0, udf1;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // Reference stacks: back of the queue is the top of stack.
  int mdl [2][$];
  bit movf [2];
  bit mudf [2];

  always #5 clk = ~clk;

  return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .d(d), .q(q0),
    .count(count0), .empty(empty0), .full(full0), .overflow(ovf0),
    .underflow(udf0), .clr_err(clr_err)
  );

  return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .d(d), .q(q1),
    .count(count1), .empty(empty1), .full(full1), .overflow(ovf1),
    .underflow(udf1), .clr_err(clr_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, obs, exp, txn);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int n;
      int eq;
      n  = mdl[k].size();
      eq = (n > 0) ? mdl[k][n-1] : 0;
      check_val($sformatf("q%0d", k),     (k == 1) ? 32'(q1) : 32'(q0), 32'(eq));
      check_val($sformatf("count%0d", k), (k == 1) ? 32'(count1) : 32'(count0), 32'(n));
      check_val($sformatf("empty%0d", k), (k == 1) ? 32'(empty1) : 32'(empty0), 32'(n == 0));
      check_val($sformatf("full%0d", k),  (k == 1) ? 32'(full1) : 32'(full0), 32'(n == DEPTH));
      check_val($sformatf("ovf%0d", k),   (k == 1) ? 32'(ovf1) : 32'(ovf0), 32'(movf[k]));
      check_val($sformatf("udf%0d", k),   (k == 1) ? 32'(udf1) : 32'(udf0), 32'(mudf[k]));
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mdl[k].delete();
      movf[k] = 1'b0;
      mudf[k] = 1'b0;
    end
  endtask

  // Stack rules applied to the reference: k=0 rejects on full, k=1 drops
  // the oldest entry instead.
  task automatic model_step(input bit p, input bit o, input int dv, input bit c);
    for (int k = 0; k < 2; k++) begin
      int n;
      bit os;
      bit us;
      n  = mdl[k].size();
      os = 1'b0;
      us = 1'b0;
      if (p && o && n > 0) begin
        mdl[k][n-1] = dv;
      end else if (p) begin
        if (n < DEPTH) begin
          mdl[k].push_back(dv);
        end else begin
          os = 1'b1;
          if (k == 1) begin
            void'(mdl[k].pop_front());
            mdl[k].push_back(dv);
          end
        end
      end else if (o) begin
        if (n > 0) void'(mdl[k].pop_back());
        else       us = 1'b1;
      end
      movf[k] = os | (movf[k] & ~c);
      mudf[k] = us | (mudf[k] & ~c);
    end
  endtask

  // One clocked transaction: inputs are applied 1 time unit after an edge,
  // sampled at the next posedge, and outputs checked 1 unit later.
  task automatic step(input bit p, input bit o, input int dv, input bit c);
    int dm;
    dm      = dv & 32'hFFF;
    push    = p;
    pop     = o;
    d       = WIDTH'(dm);
    clr_err = c;
    @(posedge clk);
    model_step(p, o, dm, c);
    #1;
    txn++;
    check_all();
    $display("txn %0d push=%0b pop=%0b d=%03h clr=%0b | rej cnt=%0d q=%03h | ovw cnt=%0d q=%03h",
             txn, p, o, dm, c, count0, q0, count1, q1);
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
  endtask

  // Assert reset between edges, check the immediate clear, then release it
  // away from any edge.
  task automatic async_reset();
    #3;
    rst = 1'b0;
    #1;
    model_clear();
    txn++;
    check_all();
    check_val("rst_q_now", 32'(q0), 32'h0);
    $display("txn %0d async reset | rej cnt=%0d q=%03h | ovw cnt=%0d q=%03h",
             txn, count0, q0, count1, q1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all();
    check_val("reset_empty", 32'(empty0), 32'h1);

    // Basic push then pop.
    step(1, 0, 'h010, 0);
    step(1, 0, 'h020, 0);
    step(1, 0, 'h030, 0);
    check_val("t1_q", 32'(q0), 32'h030);
    check_val("t1_count", 32'(count0), 32'd3);
    step(0, 1, 0, 0);
    check_val("t1_pop1", 32'(q0), 32'h020);
    step(0, 1, 0, 0);
    check_val("t1_pop2", 32'(q0), 32'h010);
    step(0, 1, 0, 0);
    check_val("t1_pop3_empty", 32'(empty0), 32'h1);

    // Fill past capacity under both policies.
    for (int i = 1; i <= 9; i++) begin
      step(1, 0, i, 0);
      if (i == 8) check_val("t2_full", 32'(full0), 32'h1);
    end
    check_val("t2_q_rej", 32'(q0), 32'h008);
    check_val("t2_ovf_rej", 32'(ovf0), 32'h1);
    step(1, 0, 'h00A, 0);
    check_val("t3_q_ovw", 32'(q1), 32'h00A);
    check_val("t3_cnt_ovw", 32'(count1), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
    end
    check_val("t3_empty_ovw", 32'(empty1), 32'h1);
    step(0, 0, 0, 1);

    // Replace top, and push+pop on empty.
    step(1, 0, 'h100, 0);
    step(1, 1, 'h1FF, 0);
    check_val("t4_replace", 32'(q0), 32'h1FF);
    step(0, 1, 0, 0);
    step(1, 1, 'h055, 0);
    check_val("t4_pp_empty", 32'(q0), 32'h055);
    check_val("t4_no_udf", 32'(udf0), 32'h0);
    step(0, 1, 0, 0);

    // Underflow, clear, and set-wins-over-clear.
    step(0, 1, 0, 0);
    check_val("t5_udf", 32'(udf0), 32'h1);
    step(0, 0, 0, 1);
    check_val("t5_clr", 32'(udf0), 32'h0);
    step(0, 1, 0, 1);
    check_val("t5_set_wins", 32'(udf0), 32'h1);

    // Asynchronous reset mid-operation.
    step(1, 0, 'h0AA, 0);
    step(1, 0, 'h0BB, 0);
    async_reset();
    step(1, 0, 'h0CC, 0);
    check_val("t6_q", 32'(q0), 32'h0CC);
    check_val("t6_count", 32'(count0), 32'd1);

    // Randomised traffic with occasional error clears and resets.
    for (int i = 0; i < 400; i++) begin
      bit p;
      bit o;
      bit c;
      p = ($urandom_range(99) < 55);
      o = ($urandom_range(99) < 45);
      c = ($urandom_range(99) < 8);
      if ($urandom_range(99) == 0) async_reset();
      else step(p, o, int'($urandom), c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Parametrised LIFO of address-width registers; holds return PCs for call/return instructions in the CA-2 datapath.
- Sits beside pc_register. Call pushes PC+1; return pops and drives the PC mux from the top entry.
- Generalises the single PC register to DEPTH entries.
- Adds push/pop handshakes, full/empty status, sticky error flags and a selectable full-stack policy.

Parameters:
- WIDTH, 12, entry width in bits (PC width).
- DEPTH, 8, number of entries; must be at least 2 (need not be a power of two).
- WRAP, 0, full policy. 0 = reject push on full and flag overflow. 1 = overwrite the oldest entry (ring behaviour).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset. Low clears all state immediately.
- push  in  1  push d this cycle.
- pop  in  1  pop top entry this cycle.
- d  in  WIDTH  value to push.
- q  out  WIDTH  current top entry, combinational from state; 0 when empty.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; set by a push rejected on full (WRAP=0) or by an overwrite (WRAP=1).
- underflow  out  1  sticky; set by pop while empty.
- clr_err  in  1  clears overflow and underflow on the next posedge.

Behaviour:
- Reset (rst=0, asynchronous):
  - count=0, empty=1, full=0, q=0, overflow=0, underflow=0.
  - Internal top/bottom pointers = 0.
  - Entry contents need not be cleared.
  - Reset mid-operation aborts any in-flight push/pop; the stack reads empty on the next cycle.
- Latency:
  - push/pop take effect at the posedge where they are sampled high.
  - q, count, empty and full reflect the new state after that edge. No read latency.
- Push only, not full: write d at top pointer, advance top pointer modulo DEPTH, count+1.
- Push only, full, WRAP=0: state unchanged, overflow<=1.
- Push only, full, WRAP=1: write d, advance top pointer, advance bottom pointer modulo DEPTH, count stays DEPTH, overflow<=1.
- Pop only, not empty: retreat top pointer modulo DEPTH, count-1. Popped value is the q visible before the edge.
- Pop only, empty: state unchanged, underflow<=1, q stays 0.
- Push and pop, not empty: replace top entry with d; count unchanged; no flags.
- Push and pop, empty: treated as push only; no underflow.
- Neither asserted: hold all state.
- clr_err:
  - Clears both sticky flags.
  - If a new error occurs in the same cycle, set wins over clear.
- Pointer arithmetic: explicit modulo DEPTH compare-and-wrap, not bit truncation, so non-power-of-two DEPTH works.
- No combinational path from push/pop/d to q, count or flags.

Decomposition:
- Package return_stack_pkg holds:
  - WRAP policy constants (POLICY_REJECT=0, POLICY_OVERWRITE=1).
  - Function ptr_inc/ptr_dec(ptr, depth) for modulo pointer step.
- One sub-module, stack_entry_bank:
  - DEPTH x WIDTH register array with a single synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr -> rdata).
  - No reset on contents.
- Top level holds pointers, count, flags and q gating (q=0 when empty).

Test Plan:
1. Reset then push 0x010, 0x020, 0x030 on three cycles -> count=3, q=0x030. Pop three cycles -> q shows 0x020, 0x010, then 0 with empty=1. No flags.
2. WRAP=0, DEPTH=8, push 0x001..0x009 -> after 8th push full=1, q=0x008. 9th push leaves q=0x008, count=8, overflow=1. Eight pops return 0x008..0x001.
3. WRAP=1, DEPTH=8, push 0x001..0x00A -> count=8, overflow=1. Eight pops return 0x00A down to 0x003, then empty=1.
4. Push 0x100, then push+pop with d=0x1FF -> count=1, q=0x1FF. Push+pop on empty with d=0x055 -> count=1, q=0x055, underflow=0.
5. Pop on empty -> underflow=1, count=0. clr_err alone -> underflow=0 next cycle. clr_err with pop on empty in same cycle -> underflow stays 1.
6. Push 0x0AA, 0x0BB, then drive rst=0 mid-cycle between edges -> count=0, empty=1, q=0, flags 0 immediately without a clock edge. After release, push 0x0CC -> q=0x0CC, count=1.
